// File: rtl/layer2_frame_seq.sv
// layer2_frame_seq: frame sequencer for the second convolution layer.
// Reads one IN_W x IN_H x 3 feature map from the layer-1 result memory in
// raster order, streams it into layer 2, then counts pooled-output strobes
// until the frame completes or the datapath goes quiet for TIMEOUT cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort, stall   frame start, synchronous abort, read back-pressure
//   busy, done            frame in progress, one-cycle end-of-frame pulse
//   err_timeout           sticky timeout flag, cleared by the next start
//   rd_en, rd_addr        memory read strobe and linear address y*IN_W + x
//   rd_data0..2           memory read data, sampled on the edge closing rd_en
//   l2_in0..2, l2_valid_in  pixel data and strobe to layer 2
//   l2_valid_out          pooled-output strobe from layer 2
//   out_cnt               pooled outputs seen in the current frame
module layer2_frame_seq #(
   parameter int unsigned IN_W      = 13,
   parameter int unsigned IN_H      = 13,
   parameter int unsigned OUT_COUNT = 36,
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 stall,
   output logic                 busy,
   output logic                 done,
   output logic                 err_timeout,
   output logic                 rd_en,
   output logic [ADDR_BITS-1:0] rd_addr,
   input  logic [11:0]          rd_data0,
   input  logic [11:0]          rd_data1,
   input  logic [11:0]          rd_data2,
   output logic [11:0]          l2_in0,
   output logic [11:0]          l2_in1,
   output logic [11:0]          l2_in2,
   output logic                 l2_valid_in,
   input  logic                 l2_valid_out,
   output logic [ADDR_BITS-1:0] out_cnt
);

   localparam int unsigned PIX_W     = 12;
   localparam int unsigned NPIX      = IN_W * IN_H;
   localparam int unsigned LAST_ADDR = NPIX - 1;
   localparam int unsigned IDLE_W    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_BITS-1:0]   issue_q, issue_d;     // next address to read
   logic                   rd_en_q, rd_en_d;
   logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
   logic [ADDR_BITS-1:0]   out_cnt_q, out_cnt_d;
   logic [IDLE_W-1:0]      idle_q, idle_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   l2_vld_q;
   logic [PIX_W-1:0]       l2_in0_q, l2_in1_q, l2_in2_q;

   logic                   cnt_sat_c;
   logic                   cnt_full_c;
   logic [IDLE_W-1:0]      idle_inc_c;

   // Control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         issue_q   <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         out_cnt_q <= '0;
         idle_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         issue_q   <= issue_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         out_cnt_q <= out_cnt_d;
         idle_q    <= idle_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      issue_d   = issue_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      out_cnt_d = out_cnt_q;
      idle_d    = idle_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;

      // Pooled-output counter saturates; strobes in IDLE are ignored
      cnt_sat_c = (out_cnt_q == ADDR_BITS'(OUT_COUNT));
      if ((state_q != ST_IDLE) && l2_valid_out && !cnt_sat_c) begin
         out_cnt_d = out_cnt_q + ADDR_BITS'(1);
      end
      cnt_full_c = (out_cnt_d == ADDR_BITS'(OUT_COUNT));
      idle_inc_c = idle_q + IDLE_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d   = ST_STREAM;
               issue_d   = '0;
               rd_addr_d = '0;
               out_cnt_d = '0;
               idle_d    = '0;
               err_d     = 1'b0;
               busy_d    = 1'b1;
            end
         end
         ST_STREAM: begin
            // One read per unstalled cycle; the last one moves to DRAIN
            if (!stall) begin
               rd_en_d   = 1'b1;
               rd_addr_d = issue_q;
               issue_d   = issue_q + ADDR_BITS'(1);
               if (issue_q == ADDR_BITS'(LAST_ADDR)) begin
                  state_d = ST_DRAIN;
                  idle_d  = '0;
               end
            end
         end
         ST_DRAIN: begin
            // Completion wins over timeout when both land on one cycle
            if (cnt_full_c) begin
               state_d = ST_FINISH;
               done_d  = 1'b1;
            end else if (l2_valid_out) begin
               idle_d = '0;
            end else if (idle_inc_c == IDLE_W'(TIMEOUT)) begin
               state_d = ST_FINISH;
               done_d  = 1'b1;
               err_d   = 1'b1;
               idle_d  = idle_inc_c;
            end else begin
               idle_d = idle_inc_c;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Abort overrides everything outside IDLE; err_timeout is left as is
      if (abort && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         rd_en_d   = 1'b0;
         rd_addr_d = rd_addr_q;
         issue_d   = issue_q;
         busy_d    = 1'b0;
         done_d    = 1'b0;
      end
   end

   // Pixel path: a read in flight is always delivered, regardless of abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l2_vld_q <= 1'b0;
         l2_in0_q <= '0;
         l2_in1_q <= '0;
         l2_in2_q <= '0;
      end else begin
         l2_vld_q <= rd_en_q;
         if (rd_en_q) begin
            l2_in0_q <= rd_data0;
            l2_in1_q <= rd_data1;
            l2_in2_q <= rd_data2;
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err_timeout = err_q;
   assign rd_en       = rd_en_q;
   assign rd_addr     = rd_addr_q;
   assign out_cnt     = out_cnt_q;
   assign l2_valid_in = l2_vld_q;
   assign l2_in0      = l2_in0_q;
   assign l2_in1      = l2_in1_q;
   assign l2_in2      = l2_in2_q;

endmodule

// File: tb/tb_layer2_frame_seq.sv
// Testbench for layer2_frame_seq: memory model, layer-2 strobe model and a
// scoreboard of expected pixels pushed on each read and popped on delivery.
module tb_layer2_frame_seq;

   localparam int unsigned AW   = 8;
   localparam int unsigned NPIX = 169;
   localparam int unsigned IW   = 13;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          stall = 1'b0;
   logic          busy, done, err_timeout, rd_en, l2_valid_in;
   logic [AW-1:0] rd_addr, out_cnt;
   logic [11:0]   rd_data0, rd_data1, rd_data2;
   logic [11:0]   l2_in0, l2_in1, l2_in2;
   logic          model_vo = 1'b0;
   logic          extra_vo = 1'b0;
   logic          l2_valid_out;

   assign l2_valid_out = model_vo | extra_vo;

   layer2_frame_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
      .busy(busy), .done(done), .err_timeout(err_timeout),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .l2_in0(l2_in0), .l2_in1(l2_in1), .l2_in2(l2_in2),
      .l2_valid_in(l2_valid_in), .l2_valid_out(l2_valid_out),
      .out_cnt(out_cnt)
   );

   always #5 clk = ~clk;

   // Distinct per-channel pixel content
   function automatic logic [11:0] pix(input int ch, input logic [7:0] a);
      return 12'((int'(a) * 37 + ch * 911 + 5) % 4096);
   endfunction

   // Memory read port; junk when not reading so stray captures show up
   assign rd_data0 = rd_en ? pix(0, rd_addr) : 12'hBAD;
   assign rd_data1 = rd_en ? pix(1, rd_addr) : 12'hBAD;
   assign rd_data2 = rd_en ? pix(2, rd_addr) : 12'hBAD;

   typedef struct {
      logic [11:0] d0;
      logic [11:0] d1;
      logic [11:0] d2;
      int          a;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   exp_addr = 0, rd_cnt = 0, vin_cnt = 0, done_cnt = 0, strobe_cnt = 0;
   int   first_rd = 0, last_rd = 0, err_rise = -1, last_strobe = 0;
   int   stall_left = 0;
   bit   stall_mode = 0, stall40_done = 0, drop_last = 0;
   logic prev_rd_en = 1'b0, prev_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor, scoreboard, layer-2 model and stall generator
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         prev_rd_en = 1'b0;
         prev_err   = 1'b0;
         model_vo   = 1'b0;
         stall      = 1'b0;
         stall_left = 0;
      end else begin
         check("vin_delay", 32'(l2_valid_in), 32'(prev_rd_en));
         if (rd_en) begin
            check("rd_addr", 32'(rd_addr), 32'(exp_addr));
            sb.push_back('{pix(0, 8'(exp_addr)), pix(1, 8'(exp_addr)), pix(2, 8'(exp_addr)), exp_addr});
            if (rd_cnt == 0) first_rd = cyc;
            last_rd = cyc;
            exp_addr++;
            rd_cnt++;
         end
         model_vo = 1'b0;
         if (l2_valid_in) begin
            vin_cnt++;
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               check("l2_in0", 32'(l2_in0), 32'(e.d0));
               check("l2_in1", 32'(l2_in1), 32'(e.d1));
               check("l2_in2", 32'(l2_in2), 32'(e.d2));
               // A pooled output completes on pixels with even x>=2 and even y>=2
               if ((e.a % IW) >= 2 && (e.a / IW) >= 2 && (e.a % IW) % 2 == 0 &&
                   (e.a / IW) % 2 == 0 && !(drop_last && e.a == NPIX - 1)) begin
                  model_vo    = 1'b1;
                  strobe_cnt++;
                  last_strobe = cyc + 1;
               end
            end
         end
         if (done) done_cnt++;
         if (err_timeout && !prev_err) err_rise = cyc;
         prev_err   = err_timeout;
         prev_rd_en = rd_en;

         stall = 1'b0;
         if (stall_mode) begin
            if (rd_en && rd_addr == 8'd40 && !stall40_done) begin
               stall_left   = 5;
               stall40_done = 1;
            end
            if (stall_left > 0) begin
               stall = 1'b1;
               stall_left--;
            end else if (busy && rd_addr >= 8'd78 && rd_addr < 8'd104) begin
               stall = cyc[0];
            end
         end
      end
   end

   task automatic reset_checks(input string t);
      check({t, "_busy"}, 32'(busy), 0);
      check({t, "_done"}, 32'(done), 0);
      check({t, "_err"}, 32'(err_timeout), 0);
      check({t, "_rd_en"}, 32'(rd_en), 0);
      check({t, "_rd_addr"}, 32'(rd_addr), 0);
      check({t, "_out_cnt"}, 32'(out_cnt), 0);
      check({t, "_vin"}, 32'(l2_valid_in), 0);
      check({t, "_l2_in0"}, 32'(l2_in0), 0);
      check({t, "_l2_in1"}, 32'(l2_in1), 0);
      check({t, "_l2_in2"}, 32'(l2_in2), 0);
   endtask

   task automatic start_frame(input string t);
      @(posedge clk); #1;
      start = 1'b1;
      exp_addr = 0; rd_cnt = 0; vin_cnt = 0; done_cnt = 0; strobe_cnt = 0; err_rise = -1;
      @(posedge clk); #1;
      start = 1'b0;
      check({t, "_busy_on"}, 32'(busy), 1);
      check({t, "_addr0"}, 32'(rd_addr), 0);
      check({t, "_cnt0"}, 32'(out_cnt), 0);
      check({t, "_err_clr"}, 32'(err_timeout), 0);
   endtask

   task automatic wait_done(input string t, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      check({t, "_done_seen"}, 32'(seen), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_addr(input string t, input int a);
      bit seen = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (rd_en && rd_addr == 8'(a)) begin
            seen = 1;
            break;
         end
      end
      check({t, "_reached"}, 32'(seen), 1);
   endtask

   task automatic frame_checks(input string t, input int exp_out, input bit exp_err);
      check({t, "_rd_cnt"}, 32'(rd_cnt), NPIX);
      check({t, "_vin_cnt"}, 32'(vin_cnt), NPIX);
      check({t, "_sb_empty"}, 32'(sb.size()), 0);
      check({t, "_done_cnt"}, 32'(done_cnt), 1);
      check({t, "_out_cnt"}, 32'(out_cnt), 32'(exp_out));
      check({t, "_err"}, 32'(err_timeout), 32'(exp_err));
      check({t, "_busy_off"}, 32'(busy), 0);
   endtask

   initial begin
      // Power-on reset
      #2 rst_n = 1'b0;
      #10;
      reset_checks("por");
      @(negedge clk); #2 rst_n = 1'b1;

      // Nominal frame
      start_frame("nom");
      wait_done("nom", 600);
      frame_checks("nom", 36, 0);
      check("nom_consecutive", 32'(last_rd - first_rd), 168);
      check("nom_strobes", 32'(strobe_cnt), 36);

      // Strobe in IDLE is ignored and out_cnt holds
      @(posedge clk); #1 extra_vo = 1'b1;
      @(posedge clk); #1 extra_vo = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_strobe_ignored", 32'(out_cnt), 36);

      // Back-pressure
      stall_mode = 1; stall40_done = 0;
      start_frame("stall");
      wait_done("stall", 900);
      frame_checks("stall", 36, 0);
      check("stall_stretched", 32'((last_rd - first_rd) >= 180), 1);
      stall_mode = 0;

      // Timeout: last pooled output never arrives
      drop_last = 1;
      start_frame("tmo");
      wait_done("tmo", 1000);
      frame_checks("tmo", 35, 1);
      check("tmo_latency", 32'(err_rise - last_strobe), 255);
      drop_last = 0;

      // Next start clears err_timeout; a start mid-frame is ignored
      start_frame("after_tmo");
      wait_addr("restart_pulse", 100);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("restart_ignored_busy", 32'(busy), 1);
      check("restart_ignored_addr", 32'(rd_addr), 101);
      wait_done("after_tmo", 600);
      frame_checks("after_tmo", 36, 0);

      // start and abort together in IDLE
      rd_cnt = 0;
      @(posedge clk); #1 start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      check("sa_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      check("sa_no_reads", 32'(rd_cnt), 0);
      check("sa_busy_later", 32'(busy), 0);

      // Abort mid-stream
      start_frame("abort");
      wait_addr("abort", 77);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_rd_en", 32'(rd_en), 0);
      check("abort_trail_vin", 32'(l2_valid_in), 1);
      @(posedge clk); #1;
      check("abort_vin_end", 32'(l2_valid_in), 0);
      repeat (5) @(negedge clk);
      check("abort_rd_cnt", 32'(rd_cnt), 78);
      check("abort_vin_cnt", 32'(vin_cnt), 78);
      check("abort_no_done", 32'(done_cnt), 0);
      check("abort_sb_empty", 32'(sb.size()), 0);
      check("abort_out_cnt", 32'(out_cnt), 12);
      check("abort_err", 32'(err_timeout), 0);
      start_frame("post_abort");
      wait_done("post_abort", 600);
      frame_checks("post_abort", 36, 0);

      // Asynchronous reset mid-frame
      start_frame("rst");
      wait_addr("rst", 150);
      #2 rst_n = 1'b0;
      #1 reset_checks("midrst");
      @(negedge clk); #2 rst_n = 1'b1;
      start_frame("post_rst");
      wait_done("post_rst", 600);
      frame_checks("post_rst", 36, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
